// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the decode-to-execute stage: datapath widths, the zero
// register index and the ALU opcode encodings.
package id_ex_stage_pkg;

    localparam int XLEN     = 32;
    localparam int REGW     = 5;
    localparam int OPW      = 5;
    localparam int REG_ZERO = 0;

    localparam logic [OPW-1:0] ALU_ADD  = 5'd0;
    localparam logic [OPW-1:0] ALU_SUB  = 5'd1;
    localparam logic [OPW-1:0] ALU_AND  = 5'd2;
    localparam logic [OPW-1:0] ALU_OR   = 5'd3;
    localparam logic [OPW-1:0] ALU_XOR  = 5'd4;
    localparam logic [OPW-1:0] ALU_SLL  = 5'd5;
    localparam logic [OPW-1:0] ALU_SRL  = 5'd6;
    localparam logic [OPW-1:0] ALU_SRA  = 5'd7;
    localparam logic [OPW-1:0] ALU_SLT  = 5'd8;
    localparam logic [OPW-1:0] ALU_SLTU = 5'd9;

endpackage

// File: rtl/id_ex_fwd_mux.sv
// Operand forwarding for one source register: x0, then EX/MEM (non-load),
// then WB, then the register-file read value.
module id_ex_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int XW = XLEN,
    parameter int RW = REGW
) (
    input  logic [RW-1:0] rs,
    input  logic [XW-1:0] rf_val,
    input  logic          exm_wb_en,
    input  logic          exm_is_load,
    input  logic [RW-1:0] exm_rd,
    input  logic [XW-1:0] exm_res,
    input  logic          wb_en,
    input  logic [RW-1:0] wb_rd,
    input  logic [XW-1:0] wb_res,
    output logic [XW-1:0] val
);

    always_comb begin
        val = rf_val;
        if (rs == RW'(REG_ZERO)) begin
            val = '0;
        end else if (exm_wb_en && !exm_is_load && exm_rd == rs) begin
            val = exm_res;
        end else if (wb_en && wb_rd == rs) begin
            val = wb_res;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubbles.
// Optional hazard-stall counter enabled by defining IDEX_STALL_CNT_EN.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_alu_op,
    input  logic [REGW-1:0]  in_rs1,
    input  logic [REGW-1:0]  in_rs2,
    input  logic [REGW-1:0]  in_rd,
    input  logic [XLEN-1:0]  in_rs1_val,
    input  logic [XLEN-1:0]  in_rs2_val,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_use_imm,
    input  logic             in_is_load,
    input  logic             in_wb_en,
    input  logic             exm_wb_en,
    input  logic             exm_is_load,
    input  logic [REGW-1:0]  exm_rd,
    input  logic [XLEN-1:0]  exm_res,
    input  logic             wb_en,
    input  logic [REGW-1:0]  wb_rd,
    input  logic [XLEN-1:0]  wb_res,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPW-1:0]   out_alu_op,
    output logic [XLEN-1:0]  out_r1,
    output logic [XLEN-1:0]  out_r2,
    output logic [REGW-1:0]  out_rd,
    output logic             out_wb_en,
    output logic             out_is_load,
    output logic [31:0]      stall_cycles
);

    // Handshake: a transfer happens on a cycle where valid & ready are both high;
    // out_* stay frozen while out_valid & ~out_ready, and nothing is accepted then.
    logic            valid_q, valid_d;
    logic [OPW-1:0]  alu_op_q, alu_op_d;
    logic [XLEN-1:0] r1_q, r1_d, r2_q, r2_d;
    logic [REGW-1:0] rd_q, rd_d;
    logic            wb_en_q, wb_en_d;
    logic            is_load_q, is_load_d;

    logic [XLEN-1:0] fwd1, fwd2;
    logic            haz1, haz2, hazard, slot_free, xfer_in, xfer_out;

    id_ex_fwd_mux #(.XW(XLEN), .RW(REGW)) u_fwd1 (
        .rs(in_rs1), .rf_val(in_rs1_val),
        .exm_wb_en(exm_wb_en), .exm_is_load(exm_is_load), .exm_rd(exm_rd), .exm_res(exm_res),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_res(wb_res), .val(fwd1)
    );

    id_ex_fwd_mux #(.XW(XLEN), .RW(REGW)) u_fwd2 (
        .rs(in_rs2), .rf_val(in_rs2_val),
        .exm_wb_en(exm_wb_en), .exm_is_load(exm_is_load), .exm_rd(exm_rd), .exm_res(exm_res),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_res(wb_res), .val(fwd2)
    );

    // A load one or two stages ahead has no data yet, so a matching source must wait.
    always_comb begin
        haz1 = (in_rs1 != REGW'(REG_ZERO)) &&
               ((valid_q && is_load_q && wb_en_q && rd_q == in_rs1) ||
                (exm_wb_en && exm_is_load && exm_rd == in_rs1));
        haz2 = !in_use_imm && (in_rs2 != REGW'(REG_ZERO)) &&
               ((valid_q && is_load_q && wb_en_q && rd_q == in_rs2) ||
                (exm_wb_en && exm_is_load && exm_rd == in_rs2));
        hazard    = haz1 || haz2;
        slot_free = !valid_q || out_ready;
        in_ready  = slot_free && !hazard && !flush;
        xfer_in   = in_valid && in_ready;
        xfer_out  = valid_q && out_ready;
    end

    always_comb begin
        valid_d   = valid_q;
        alu_op_d  = alu_op_q;
        r1_d      = r1_q;
        r2_d      = r2_q;
        rd_d      = rd_q;
        wb_en_d   = wb_en_q;
        is_load_d = is_load_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (xfer_in) begin
            valid_d   = 1'b1;
            alu_op_d  = in_alu_op;
            r1_d      = fwd1;
            r2_d      = in_use_imm ? in_imm : fwd2;
            rd_d      = in_rd;
            wb_en_d   = in_wb_en;
            is_load_d = in_is_load;
        end else if (xfer_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            alu_op_q  <= '0;
            r1_q      <= '0;
            r2_q      <= '0;
            rd_q      <= '0;
            wb_en_q   <= 1'b0;
            is_load_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            alu_op_q  <= alu_op_d;
            r1_q      <= r1_d;
            r2_q      <= r2_d;
            rd_q      <= rd_d;
            wb_en_q   <= wb_en_d;
            is_load_q <= is_load_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_alu_op  = alu_op_q;
    assign out_r1      = r1_q;
    assign out_r2      = r2_q;
    assign out_rd      = rd_q;
    assign out_wb_en   = wb_en_q;
    assign out_is_load = is_load_q;

`ifdef IDEX_STALL_CNT_EN
    // Counts only hazard stalls; back-pressure cycles are not included.
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (in_valid && !flush && hazard && slot_free) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding vector table plus load-use,
// back-pressure, flush and asynchronous-reset sequences.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

`ifdef IDEX_STALL_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready;
    logic [OPW-1:0]  in_alu_op;
    logic [REGW-1:0] in_rs1, in_rs2, in_rd;
    logic [XLEN-1:0] in_rs1_val, in_rs2_val, in_imm;
    logic            in_use_imm, in_is_load, in_wb_en;
    logic            exm_wb_en, exm_is_load;
    logic [REGW-1:0] exm_rd;
    logic [XLEN-1:0] exm_res;
    logic            wb_en;
    logic [REGW-1:0] wb_rd;
    logic [XLEN-1:0] wb_res;
    logic            flush;
    logic            out_valid, out_ready;
    logic [OPW-1:0]  out_alu_op;
    logic [XLEN-1:0] out_r1, out_r2;
    logic [REGW-1:0] out_rd;
    logic            out_wb_en, out_is_load;
    logic [31:0]     stall_cycles;

    int checks = 0;
    int failures = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_is_load(in_is_load), .in_wb_en(in_wb_en),
        .exm_wb_en(exm_wb_en), .exm_is_load(exm_is_load), .exm_rd(exm_rd), .exm_res(exm_res),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_res(wb_res),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_r1(out_r1), .out_r2(out_r2), .out_rd(out_rd),
        .out_wb_en(out_wb_en), .out_is_load(out_is_load), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OPW-1:0]  op;
        logic [REGW-1:0] rs1, rs2, rd;
        logic [XLEN-1:0] v1, v2, imm;
        logic            use_imm;
        logic            x_en, x_ld;
        logic [REGW-1:0] x_rd;
        logic [XLEN-1:0] x_res;
        logic            w_en;
        logic [REGW-1:0] w_rd;
        logic [XLEN-1:0] w_res;
        logic [XLEN-1:0] exp_r1, exp_r2;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_alu_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_rs1_val = '0; in_rs2_val = '0; in_imm = '0;
        in_use_imm = 0; in_is_load = 0; in_wb_en = 0;
        exm_wb_en = 0; exm_is_load = 0; exm_rd = '0; exm_res = '0;
        wb_en = 0; wb_rd = '0; wb_res = '0;
        flush = 0; out_ready = 1;
    endtask

    task automatic drive(input logic [OPW-1:0] op, input logic [REGW-1:0] rs1, input logic [REGW-1:0] rs2,
                         input logic [REGW-1:0] rd, input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2,
                         input logic is_load);
        in_valid = 1; in_alu_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rs1_val = v1; in_rs2_val = v2; in_imm = '0; in_use_imm = 0;
        in_is_load = is_load; in_wb_en = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_r1", out_r1, 0);
        chk("rst_out_r2", out_r2, 0);
        chk("rst_out_op", 32'(out_alu_op), 0);
        chk("rst_out_rd", 32'(out_rd), 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        step();
        rst = 0;
        step();

        // {op, rs1, rs2, rd, v1, v2, imm, use_imm, exm en/ld/rd/res, wb en/rd/res, exp r1, exp r2}
        vecs[0] = '{ALU_ADD, 5'd3, 5'd4, 5'd1, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd10, 32'd20};
        vecs[1] = '{ALU_SUB, 5'd3, 5'd4, 5'd2, 32'd1, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h55, 1'b1, 5'd3, 32'h66, 32'h55, 32'd7};
        vecs[2] = '{ALU_AND, 5'd0, 5'd3, 5'd2, 32'd1, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h55, 1'b1, 5'd3, 32'h66, 32'd0, 32'h55};
        vecs[3] = '{ALU_OR, 5'd9, 5'd4, 5'd6, 32'h11, 32'h22, 32'd0, 1'b0, 1'b0, 1'b0, 5'd4, 32'h77, 1'b1, 5'd4, 32'h66, 32'h11, 32'h66};
        vecs[4] = '{ALU_XOR, 5'd3, 5'd3, 5'd6, 32'h1, 32'h2, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h55, 1'b0, 5'd0, 32'd0, 32'h55, 32'hFFFF_FFF0};
        vecs[5] = '{ALU_SLL, 5'd3, 5'd8, 5'd6, 32'hA5A5, 32'h5A5A, 32'd0, 1'b0, 1'b0, 1'b0, 5'd3, 32'h55, 1'b0, 5'd8, 32'h99, 32'hA5A5, 32'h5A5A};
        vecs[6] = '{ALU_SRA, 5'd0, 5'd0, 5'd0, 32'h1234, 32'h5678, 32'd0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 32'd0, 32'd0};
        vecs[7] = '{ALU_SLT, 5'd12, 5'd13, 5'd31, 32'h1, 32'h2, 32'd0, 1'b0, 1'b1, 1'b0, 5'd13, 32'hBEEF, 1'b1, 5'd12, 32'hF00D, 32'hF00D, 32'hBEEF};

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].v1, vecs[i].v2, 1'b0);
            in_imm = vecs[i].imm; in_use_imm = vecs[i].use_imm;
            exm_wb_en = vecs[i].x_en; exm_is_load = vecs[i].x_ld; exm_rd = vecs[i].x_rd; exm_res = vecs[i].x_res;
            wb_en = vecs[i].w_en; wb_rd = vecs[i].w_rd; wb_res = vecs[i].w_res;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 1);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("vec%0d_op", i), 32'(out_alu_op), 32'(vecs[i].op));
            chk($sformatf("vec%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_r1", i), out_r1, vecs[i].exp_r1);
            chk($sformatf("vec%0d_r2", i), out_r2, vecs[i].exp_r2);
        end

        // Load-use: two bubbles, then operand taken from WB.
        idle();
        drive(ALU_ADD, 5'd1, 5'd2, 5'd5, 32'd0, 32'd0, 1'b1);
        step();
        chk("lu_load_held", 32'(out_is_load), 1);
        drive(ALU_ADD, 5'd6, 5'd5, 5'd7, 32'h66, 32'hDEAD, 1'b0);
        #1;
        chk("lu_stall1", 32'(in_ready), 0);
        step();
        exm_wb_en = 1; exm_is_load = 1; exm_rd = 5'd5; exm_res = 32'h0BAD;
        #1;
        chk("lu_bubble", 32'(out_valid), 0);
        chk("lu_stall2", 32'(in_ready), 0);
        step();
        exm_wb_en = 0; exm_is_load = 0; exm_rd = '0;
        wb_en = 1; wb_rd = 5'd5; wb_res = 32'hCAFE;
        #1;
        chk("lu_accept", 32'(in_ready), 1);
        step();
        chk("lu_valid", 32'(out_valid), 1);
        chk("lu_r1", out_r1, 32'h66);
        chk("lu_r2", out_r2, 32'hCAFE);
        chk("lu_rd", 32'(out_rd), 7);
        chk("lu_stall_cnt", stall_cycles, 32'(2 * CNT_ON));

        // Back-pressure: held entry must not change for three cycles.
        idle();
        drive(ALU_ADD, 5'd2, 5'd0, 5'd8, 32'h111, 32'd0, 1'b0);
        step();
        out_ready = 0;
        drive(ALU_SUB, 5'd2, 5'd0, 5'd9, 32'h222, 32'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 0);
            step();
            chk($sformatf("bp%0d_valid", c), 32'(out_valid), 1);
            chk($sformatf("bp%0d_r1", c), out_r1, 32'h111);
            chk($sformatf("bp%0d_rd", c), 32'(out_rd), 8);
        end
        out_ready = 1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 1);
        step();
        chk("bp_next_r1", out_r1, 32'h222);
        chk("bp_next_rd", 32'(out_rd), 9);
        chk("bp_next_op", 32'(out_alu_op), 32'(ALU_SUB));

        // Flush with a held entry and an incoming instruction.
        out_ready = 0;
        flush = 1;
        drive(ALU_OR, 5'd3, 5'd0, 5'd10, 32'h333, 32'd0, 1'b0);
        #1;
        chk("fl_in_ready", 32'(in_ready), 0);
        step();
        chk("fl_valid", 32'(out_valid), 0);
        idle();
        step();
        chk("fl_dropped", 32'(out_valid), 0);

        // Hazard stalls from an EX/MEM load, then async reset while a load is held.
        exm_wb_en = 1; exm_is_load = 1; exm_rd = 5'd5;
        drive(ALU_ADD, 5'd5, 5'd0, 5'd11, 32'h44, 32'd0, 1'b0);
        step();
        step();
        chk("exm_stall_ready", 32'(in_ready), 0);
        chk("exm_stall_cnt", stall_cycles, 32'(4 * CNT_ON));
        idle();
        drive(ALU_ADD, 5'd1, 5'd0, 5'd5, 32'h1, 32'd0, 1'b1);
        step();
        out_ready = 0;
        drive(ALU_ADD, 5'd5, 5'd0, 5'd12, 32'h88, 32'd0, 1'b0);
        #1;
        chk("rs_stall_ready", 32'(in_ready), 0);
        #2;
        rst = 1;
        #1;
        chk("rs_valid", 32'(out_valid), 0);
        chk("rs_r1", out_r1, 0);
        chk("rs_rd", 32'(out_rd), 0);
        chk("rs_load", 32'(out_is_load), 0);
        chk("rs_stall_cnt", stall_cycles, 0);
        chk("rs_in_ready", 32'(in_ready), 1);
        #1;
        rst = 0;
        out_ready = 1;
        step();
        chk("rs_after_valid", 32'(out_valid), 1);
        chk("rs_after_r1", out_r1, 32'h88);
        chk("rs_after_rd", 32'(out_rd), 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that sits directly upstream of the ALU.
- Captures one decoded instruction per transfer and resolves operand forwarding from the two later stages (EX/MEM, WB).
- Detects load-use hazards and inserts bubbles.
- Presents registered `alu_op` / `r1` / `r2` to the ALU with a valid/ready handshake, and supports flush on branch redirect.

Parameters:
- XLEN, 32, datapath width (ALU operands/result).
- REGW, 5, register index width.
- OPW, 5, ALU opcode width; encodings from aluops.vh.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  decode has an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_alu_op  in  OPW  ALU opcode.
- in_rs1, in_rs2  in  REGW  source register indices.
- in_rd  in  REGW  destination index.
- in_rs1_val, in_rs2_val  in  XLEN  register-file read data.
- in_imm  in  XLEN  sign-extended immediate.
- in_use_imm  in  1  r2 takes imm; rs2 unused.
- in_is_load  in  1  instruction is a load.
- in_wb_en  in  1  instruction writes rd.
- exm_wb_en, exm_is_load  in  1  EX/MEM-stage instruction writes rd / is a load.
- exm_rd  in  REGW  EX/MEM destination.
- exm_res  in  XLEN  EX/MEM ALU result.
- wb_en  in  1  WB write enable.
- wb_rd  in  REGW  WB destination.
- wb_res  in  XLEN  WB data.
- flush  in  1  kill held and incoming instruction.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  execute consumes.
- out_alu_op  out  OPW.
- out_r1, out_r2  out  XLEN  resolved operands.
- out_rd  out  REGW.
- out_wb_en, out_is_load  out  1.
- stall_cycles  out  32  hazard-stall count (see Optional Feature).

Behaviour:
- Reset (async, rst=1): out_valid=0, every out_* data field=0, stall_cycles=0. in_ready follows its combinational equation (reset out_valid=0, so in_ready=1 unless a hazard is present).
- Latency: one cycle from accepted input to out_valid.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- out_* must hold stable while out_valid & ~out_ready.
- rs1_used = 1. rs2_used = ~in_use_imm.
- Load-use hazard (combinational) when rs is used, nonzero, and either:
  - (out_valid & out_is_load & out_wb_en & out_rd==rs), or
  - (exm_wb_en & exm_is_load & exm_rd==rs).
- in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
- Register update, in priority order:
  1. flush: out_valid<=0.
  2. Transfer in: capture all fields, out_valid<=1.
  3. Transfer out without transfer in: out_valid<=0 (bubble).
  4. Otherwise hold.
- Forwarding per source, evaluated at capture, in priority:
  1. rs==0 -> 0.
  2. exm_wb_en & ~exm_is_load & exm_rd==rs -> exm_res.
  3. wb_en & wb_rd==rs -> wb_res.
  4. Otherwise the register-file value.
- out_r1 = fwd(rs1).
- out_r2 = in_use_imm ? in_imm : fwd(rs2).
- Captured operands are final: later writebacks never modify a held entry.
- Back-to-back load-use costs exactly 2 bubble cycles: load in ALU stage, then load in EX/MEM stage; the value is forwarded from WB on the third cycle.
- Load into x0 never causes a hazard.
- flush with in_valid=1: instruction dropped, in_ready=0 that cycle.
- rst mid-stall: entry discarded immediately; no partial state survives.
- Handshake invariant: no transfer in while out_valid & ~out_ready.

Optional Feature:
- Macro: IDEX_STALL_CNT_EN.
- Defined: stall_cycles increments (wraps at 2^32) every cycle with in_valid & ~flush & hazard & (~out_valid | out_ready), i.e. hazard-only stalls, not back-pressure. Cleared by rst.
- Undefined: no counter flops; stall_cycles tied to 0.

Decomposition:
- Shared package/header: ALU opcode macros (existing aluops.vh), XLEN/REGW constants, a REG_ZERO constant.
- One natural sub-module: id_ex_fwd_mux — purely combinational, instantiated twice (rs1, rs2). Inputs: rs, rf_val, exm_*, wb_*. Output: resolved value.

Test Plan:
- ADD rs1=3, rs2=4, rf=10/20, no matching rd anywhere -> next cycle out_valid=1, out_r1=10, out_r2=20, out_alu_op=`ADD.
- exm_rd=3, exm_res=0x55, wb_rd=3, wb_res=0x66, capture rs1=3 -> out_r1=0x55 (EX/MEM priority). Repeat with rs1=0 -> out_r1=0.
- Load rd=5 in the register; next instruction uses rs2=5, in_use_imm=0 -> in_ready=0 for 2 cycles while the load is in the register and then in EX/MEM. Third cycle: accepted with out_r2=wb_res. stall_cycles=2 when IDEX_STALL_CNT_EN is defined.
- out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_* unchanged. Raise out_ready -> next instruction appears next cycle.
- flush asserted with held entry and in_valid=1 -> out_valid=0 next cycle, incoming dropped.
- rst asserted mid-stall, asynchronously -> out_valid=0 and stall_cycles=0 before the next edge. After release, first in_valid transfers normally.
